tc_pl_bus_tx_ctl_mc: RTL
========================

// Module: tc_pl_bus_tx_ctl_mc
// PURPOSE
//  Multi-channel PL bus transmit sequencer. Latches per-channel tx triggers and grants the shared bus round-robin.
//  For the granted channel it alternates chip-select (CSN) and data (TXD) phases word by word until that
//  channel's TX buffer is empty or a per-grant word limit is reached.
//  Sits between N TX buffers and the shared CSN/TXD serialisers in the PL bus transmit path.
// PARAMETERS
//  CH_NUM     4     number of TX channels (>=2)
//  CH_W       2     width of ch_sel, >= clog2(CH_NUM)
//  MAX_WORDS  16    max words per grant before re-arbitration (1..2^CNT_W-1)
//  CNT_W      8     width of per-grant word counter
//  TO_CYCLES  1024  handshake timeout in clk cycles (TX_TIMEOUT_EN only)
//  TO_W       16    width of timeout counter
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous reset, active-high
//  tx_trig    in   CH_NUM  per-channel start request, 1-cycle pulse
//  txb_empty  in   CH_NUM  per-channel TX buffer empty flag
//  tx_ting    out  CH_NUM  channel currently being served (one-hot or zero)
//  tx_cmpt    out  CH_NUM  1-cycle pulse: grant to that channel finished
//  tx_err     out  CH_NUM  1-cycle pulse: grant aborted by timeout (0 without TX_TIMEOUT_EN)
//  ch_sel     out  CH_W    index of granted channel, steers buffer/serialiser mux
//  csn_en     out  1       request CSN phase, held until csn_cmpt
//  csn_cmpt   in   1       CSN phase done, 1-cycle pulse
//  txd_en     out  1       request TXD phase, held until txd_cmpt
//  txd_cmpt   in   1       TXD phase done, 1-cycle pulse
// BEHAVIOUR
//  - Reset (async, any state): state=S_IDLE, pending=0, rr_ptr=0, word_cnt=0, all outputs 0, ch_sel=0.
//  - pending[i] set on tx_trig[i]. Cleared only when channel i's grant ends with txb_empty[i]=1 or by timeout.
//    A trig while channel i is already pending or served is absorbed; no second request is queued.
//  - S_IDLE: if pending!=0, grant first pending channel at or after rr_ptr (wrap CH_NUM-1 -> 0).
//    Set ch_sel, tx_ting[g]=1, csn_en=1, word_cnt=0, go S_CSN. Grant visible 1 cycle after pending is seen.
//  - S_CSN: if txb_empty[g] -> S_CMPT (checked before csn_cmpt; empty wins a same-cycle tie).
//    Else on csn_cmpt: csn_en=0, txd_en=1 -> S_TXD.
//  - S_TXD: on txd_cmpt: txd_en=0, word_cnt+1.
//    If new word_cnt==MAX_WORDS -> S_CMPT with pending[g] kept (buffer not drained). Else csn_en=1 -> S_CSN.
//  - S_CMPT (1 cycle): tx_cmpt[g]=1 pulse, tx_ting[g]=0, csn_en=txd_en=0, rr_ptr=g+1 (wrap), go S_IDLE.
//    pending[g] is cleared here if txb_empty[g]=1.
//  - A channel hitting MAX_WORDS is re-arbitrated after all other pending channels: fairness guaranteed.
//  - csn_en and txd_en are never high together. At most one tx_ting bit is set. Minimum idle gap between grants: 1 cycle.
//  - csn_cmpt/txd_cmpt outside their matching phase are ignored.
//  - tx_trig[g] during S_CMPT of the same channel: pending stays or re-sets; channel is served again later.
// CONFIGURATION
//  - TX_TIMEOUT_EN defined: a counter runs in S_CSN/S_TXD and is cleared on every state change.
//    If it reaches TO_CYCLES: tx_err[g]=1 pulse, pending[g] cleared, enables dropped, go S_CMPT.
//    tx_cmpt[g] still pulses in S_CMPT.
//  - TX_TIMEOUT_EN undefined: no counter. tx_err tied 0. The block waits indefinitely for handshakes.
// TESTING
//  - Single: trig[0], empty[0] drops after 3 words -> csn/txd alternate 3x, tx_cmpt[0] pulse, ting[0] 1->0.
//  - Empty on grant: trig[2] with empty[2]=1 -> S_CSN then S_CMPT, tx_cmpt[2] pulse, no txd_en.
//  - Round-robin: trig[0..3] same cycle -> grants 0,1,2,3 in order, ch_sel matches, one ting bit at a time.
//  - Word limit: MAX_WORDS=4, ch1 never empty, ch3 pending -> ch1 4 words, ch3 served, ch1 again.
//  - Reset mid-TXD: assert rst -> all outputs 0 immediately; after release, no grant without new trig.
//  - TX_TIMEOUT_EN, TO_CYCLES=8: withhold csn_cmpt -> tx_err[g] and tx_cmpt[g] pulse; pending[g]=0.

Source files
------------

// File: rtl/tc_pl_bus_tx_ctl_mc.sv
// Multi-channel PL bus transmit sequencer.
// Latches per-channel tx triggers, grants the shared CSN/TXD bus round-robin and
// alternates CSN and TXD phases word by word for the granted channel. A grant ends
// when that channel's buffer runs empty or after MAX_WORDS words. A channel cut off
// by the word limit keeps its request and queues behind every other pending channel.
// Optional feature macro: TX_TIMEOUT_EN (handshake timeout, reported on tx_err).
module tc_pl_bus_tx_ctl_mc #(
  parameter int CH_NUM    = 4,
  parameter int CH_W      = 2,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = 8,
  parameter int TO_CYCLES = 1024,
  parameter int TO_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] tx_trig,
  input  logic [CH_NUM-1:0] txb_empty,
  output logic [CH_NUM-1:0] tx_ting,
  output logic [CH_NUM-1:0] tx_cmpt,
  output logic [CH_NUM-1:0] tx_err,
  output logic [CH_W-1:0]   ch_sel,
  output logic              csn_en,
  input  logic              csn_cmpt,
  output logic              txd_en,
  input  logic              txd_cmpt
);

  typedef enum logic [1:0] {S_IDLE, S_CSN, S_TXD, S_CMPT} state_t;

  state_t            state, state_n;
  logic [CH_NUM-1:0] pending, pending_n;
  logic [CH_W-1:0]   rr_ptr, rr_n;
  logic [CNT_W-1:0]  word_cnt, wc_n;
  logic [CH_W-1:0]   sel_n;
  logic [CH_NUM-1:0] ting_n, cmpt_n, err_n, clr;
  logic              csn_n, txd_n, go_cmpt;
  logic [CH_W-1:0]   pick;
  logic              found;
  logic [CH_NUM-1:0] sel_oh, pick_oh;
  logic              to_hit;

  assign sel_oh  = {{(CH_NUM-1){1'b0}}, 1'b1} << ch_sel;
  assign pick_oh = {{(CH_NUM-1){1'b0}}, 1'b1} << pick;

  // round-robin pick: first pending channel at or after rr_ptr, wrapping at CH_NUM
  always_comb begin
    logic [CH_W:0] sum;
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(CH_NUM)) sum = sum - (CH_W+1)'(CH_NUM);
      if (!found && pending[sum[CH_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[CH_W-1:0];
      end
    end
  end

`ifdef TX_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            waiting;

  assign waiting = (state == S_CSN) || (state == S_TXD);
  assign to_hit  = waiting && (to_cnt == TO_W'(TO_CYCLES - 1));

  // cycles spent waiting for the current handshake; any state change restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              to_cnt <= '0;
    else if (!waiting || state_n != state) to_cnt <= '0;
    else                                  to_cnt <= to_cnt + 1'b1;
  end
`else
  // no timeout: the sequencer waits on handshakes indefinitely
  assign to_hit = 1'b0;
`endif

  // next-state and next-output logic; outputs are registered from these values
  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    wc_n    = word_cnt;
    sel_n   = ch_sel;
    ting_n  = tx_ting;
    cmpt_n  = '0;
    err_n   = '0;
    csn_n   = csn_en;
    txd_n   = txd_en;
    clr     = '0;
    go_cmpt = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          sel_n   = pick;
          ting_n  = pick_oh;
          csn_n   = 1'b1;
          wc_n    = '0;
          state_n = S_CSN;
        end
      end
      S_CSN: begin
        // an empty buffer ends the grant even if csn_cmpt arrives in the same cycle
        if (txb_empty[ch_sel]) begin
          go_cmpt = 1'b1;
        end else if (csn_cmpt) begin
          csn_n   = 1'b0;
          txd_n   = 1'b1;
          state_n = S_TXD;
        end else if (to_hit) begin
          go_cmpt = 1'b1;
          err_n   = sel_oh;
          clr     = sel_oh;
        end
      end
      S_TXD: begin
        if (txd_cmpt) begin
          txd_n = 1'b0;
          wc_n  = word_cnt + 1'b1;
          if (wc_n == CNT_W'(MAX_WORDS)) begin
            go_cmpt = 1'b1;
          end else begin
            csn_n   = 1'b1;
            state_n = S_CSN;
          end
        end else if (to_hit) begin
          go_cmpt = 1'b1;
          err_n   = sel_oh;
          clr     = sel_oh;
        end
      end
      S_CMPT: begin
        state_n = S_IDLE;
        rr_n    = (ch_sel == CH_W'(CH_NUM - 1)) ? '0 : ch_sel + 1'b1;
        // a word-limited grant keeps its request unless the buffer drained meanwhile
        if (txb_empty[ch_sel]) clr = clr | sel_oh;
      end
      default: state_n = S_IDLE;
    endcase
    if (go_cmpt) begin
      state_n = S_CMPT;
      cmpt_n  = sel_oh;
      ting_n  = '0;
      csn_n   = 1'b0;
      txd_n   = 1'b0;
    end
    // a new trigger wins over a same-cycle clear, so the channel is served again later
    pending_n = (pending & ~clr) | tx_trig;
  end

  // state register plus registered bus-control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pending  <= '0;
      rr_ptr   <= '0;
      word_cnt <= '0;
      ch_sel   <= '0;
      tx_ting  <= '0;
      tx_cmpt  <= '0;
      tx_err   <= '0;
      csn_en   <= 1'b0;
      txd_en   <= 1'b0;
    end else begin
      state    <= state_n;
      pending  <= pending_n;
      rr_ptr   <= rr_n;
      word_cnt <= wc_n;
      ch_sel   <= sel_n;
      tx_ting  <= ting_n;
      tx_cmpt  <= cmpt_n;
      tx_err   <= err_n;
      csn_en   <= csn_n;
      txd_en   <= txd_n;
    end
  end

endmodule
